// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, defaults, fetch state encoding and IF/ID payload for the fetch stage.
package if_stage_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
  } if_id_t;
endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble beats load, neither means hold.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              bubble,
  input  if_id_t            data,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc4,
  output logic              id_valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      id_inst  <= NOP_INST;
      id_pc    <= '0;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (bubble) begin
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (load) begin
      id_inst  <= data.inst;
      id_pc    <= data.pc;
      id_pc4   <= data.pc4;
      id_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, variable-latency imem fetch FSM, 1-entry stall buffer and IF/ID register.
// Optional IF_PERF_CNT_EN adds delivered-word and bubble-cycle counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc4,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_bubble_cnt,
`endif
  output logic              id_valid
);
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc4;
  logic [INST_W-1:0] hold_inst, hold_inst_n;
  logic kill, kill_n, load, bubble, ack_live;
  if_id_t data;
  assign pc4 = pc + 32'd4;
  assign imem_addr = pc;
  // A redirect in FETCH retargets the PC, so the stale request is never issued.
  assign imem_req = state == S_FETCH && !redirect && !rst;
  always_comb begin
    ack_live = state == S_WAIT && imem_ack && !kill;
    load = !redirect && !stall && (ack_live || state == S_HOLD);
    bubble = redirect || (!stall && !load);
    data = '{inst: state == S_HOLD ? hold_inst : imem_rdata, pc: pc, pc4: pc4};
    pc_n = redirect ? (redirect_pc & ~32'h3) : load ? pc4 : pc;
    hold_inst_n = redirect ? NOP_INST : (ack_live && stall) ? imem_rdata : hold_inst;
    kill_n = state == S_WAIT && !imem_ack && (redirect || kill);
    state_n = redirect ? ((state == S_WAIT && !imem_ack) ? S_WAIT : S_FETCH)
            : state == S_FETCH ? S_WAIT
            : state == S_HOLD ? (stall ? S_HOLD : S_FETCH)
            : !imem_ack ? S_WAIT
            : (kill || !stall) ? S_FETCH : S_HOLD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      hold_inst <= NOP_INST;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      kill      <= kill_n;
      hold_inst <= hold_inst_n;
    end
  end
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk(clk),
    .rst(rst),
    .load(load),
    .bubble(bubble),
    .data(data),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .id_pc4(id_pc4),
    .id_valid(id_valid)
  );
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      perf_fetch_cnt  <= perf_fetch_cnt + 32'(load);
      perf_bubble_cnt <= perf_bubble_cnt + 32'(bubble);
    end
  end
`endif
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns the PC and issues requests to instruction memory, which has variable latency.
- Absorbs stalls from the hazard unit and taken-branch/jump redirects from decode.
- Presents `id_inst` / `id_pc` / `id_pc4` / `id_valid` to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word driven into decode for bubbles (addi x0,x0,0).

Ports:
- clk in 1: single clock, all state on rising edge.
- rst in 1: synchronous, active-high reset.
- stall in 1: hazard unit; hold IF/ID contents and PC.
- redirect in 1: decode resolved taken branch/jal/jalr this cycle.
- redirect_pc in 32: target for redirect; bits [1:0] forced to 0 internally.
- imem_req out 1: fetch request valid.
- imem_addr out 32: fetch address, equals current PC.
- imem_ack in 1: instruction data valid this cycle; ≥1 cycle after request accepted.
- imem_rdata in 32: instruction word, valid with imem_ack.
- id_inst out 32: IF/ID instruction.
- id_pc out 32: IF/ID PC.
- id_pc4 out 32: id_pc+4.
- id_valid out 1: IF/ID holds a real instruction.

Behaviour:
- Reset values (sync, active-high): pc=RESET_PC; id_inst=NOP_INST; id_pc=0; id_pc4=0; id_valid=0; imem_req=0; state=FETCH; kill=0; hold buffer empty.
- FSM states:
  - FETCH: drive imem_req=1, imem_addr=pc; go to WAIT next cycle. Request is a single-cycle pulse.
  - WAIT: imem_req=0; wait for imem_ack.
  - HOLD: fetched word parked in 1-entry buffer because stall was high at ack.
- On imem_ack in WAIT:
  - kill=1: discard data, clear kill, go to FETCH (pc already holds the redirect target).
  - Otherwise, stall=0: load IF/ID with {imem_rdata, pc, pc+4, valid=1}; pc<=pc+4; go to FETCH.
  - Otherwise, stall=1: store word in buffer, go to HOLD.
- HOLD: when stall drops, load IF/ID from buffer, pc<=pc+4, go to FETCH.
- While no new word is loaded and stall=0: IF/ID gets a bubble (id_inst=NOP_INST, id_valid=0). Decode never sees a repeated instruction.
- While stall=1: IF/ID holds its value unchanged.
- Fetch latency: best case one instruction per 2 cycles (FETCH+WAIT with ack next cycle). Fetch-to-id_* latency = ack cycle + 1.
- Redirect has highest priority, including over stall:
  - pc<=redirect_pc & ~3; IF/ID<=bubble.
  - Buffer cleared. Next state: FETCH from FETCH/HOLD; from WAIT, stay WAIT with kill=1.
  - If redirect coincides with imem_ack in WAIT, the returning word is discarded and the next state is FETCH.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Reset asserted mid-WAIT: state returns to FETCH. A late imem_ack while in FETCH/HOLD is ignored.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, add outputs:
  - perf_fetch_cnt out 32: count of words delivered to IF/ID.
  - perf_bubble_cnt out 32: count of cycles IF/ID loaded a bubble.
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - NOP_INST and RESET_PC defaults.
  - Fetch state encoding {FETCH, WAIT, HOLD} as 2-bit localparams.
  - INST_W=32, ADDR_W=32.
- One sub-module: if_id_reg.
  - Holds id_inst/id_pc/id_pc4/id_valid.
  - Inputs: load, bubble, data.
  - Hold when neither load nor bubble is asserted.
- FSM, PC and buffer stay in if_stage.

Test Plan:
- Reset, imem_ack one cycle after each req, rdata=0x00500093 → first id_valid=1 at cycle 3 with id_pc=0, id_pc4=4; imem_addr sequence 0,4,8.
- stall=1 for 3 cycles spanning an ack with word 0x00A00113 at pc=8 → IF/ID holds previous word; state HOLD. On release, id_inst=0x00A00113, id_pc=8, next imem_addr=0xC.
- redirect=1, redirect_pc=0x103 while in WAIT; ack later returns 0xDEADBEEF → word discarded, id_valid=0; next imem_addr=0x100.
- redirect and stall asserted together in HOLD → buffer dropped, IF/ID bubble (id_inst=0x13), next imem_addr=redirect target.
- pc=0xFFFFFFFC fetch, ack → id_pc4=0, next imem_addr=0.
- With IF_PERF_CNT_EN: 10 delivered words and 4 bubble cycles → perf_fetch_cnt=10, perf_bubble_cnt=4; rst clears both.
